hd44780_ctrl: RTL

Sequencer that drives an HD44780-compatible character LCD over its 8-bit parallel bus, write-only. After reset it performs the power-on wait and the instruction-set initialisation. It then fetches two lines of text from the combinational character ROM (7-bit DDRAM-style address in, 8-bit character out) and writes them to display RAM. It sits between the character ROM and the LCD pins and is the only user of both.

---
 rtl/hd44780_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/hd44780_ctrl.sv
// rtl/hd44780_ctrl.sv - write-only HD44780 8-bit bus sequencer: power-on init, then two ROM text lines
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   refresh   one-cycle pulse requesting a rewrite of both text lines
//   rom_addr  character ROM address (line 0 at 0x00+i, line 1 at 0x40+i)
//   rom_data  character ROM data, combinational from rom_addr
//   lcd_rs    0 = instruction, 1 = data
//   lcd_rw    always 0 (write only)
//   lcd_e     enable strobe
//   lcd_db    8-bit data bus
//   busy      a sequence is in progress
//   done      first full text pass finished; sticky until reset

module hd44780_ctrl #(
  parameter int CYC_US   = 12,
  parameter int POR_US   = 40000,
  parameter int LINE_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refresh,
  output logic [6:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_POR   = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EHIGH = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_FETCH = 3'd5;
  localparam logic [2:0] S_IDLE  = 3'd6;

  // Counter reload values are "cycles - 1": a phase ends on the cycle the counter reads zero.
  localparam logic [23:0] T_POR  = 24'(POR_US * CYC_US - 1);
  localparam logic [23:0] T_US   = 24'(CYC_US - 1);
  localparam logic [23:0] T_40   = 24'(40 * CYC_US - 1);
  localparam logic [23:0] T_100  = 24'(100 * CYC_US - 1);
  localparam logic [23:0] T_1640 = 24'(1640 * CYC_US - 1);
  localparam logic [23:0] T_4100 = 24'(4100 * CYC_US - 1);
  localparam logic [5:0]  LAST_CHR = 6'(LINE_LEN - 1);

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd4:    return 8'h08;
      3'd5:    return 8'h01;
      3'd6:    return 8'h06;
      3'd7:    return 8'h0C;
      default: return 8'h38;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        in_text_q, in_text_d;
  logic [2:0]  init_idx_q, init_idx_d;
  logic        line_q, line_d;
  logic        cmd_q, cmd_d;          // current text write is the line-address instruction
  logic [5:0]  chr_q, chr_d;
  logic        pend_q, pend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [7:0]  db_q, db_d;
  logic [6:0]  addr_q, addr_d;
  logic        start_text;
  logic        cnt_zero;
  logic [2:0]  init_nxt;
  logic [5:0]  chr_nxt;

  assign cnt_zero = (cnt_q == 24'd0);
  assign init_nxt = init_idx_q + 3'd1;
  assign chr_nxt  = chr_q + 6'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_zero ? cnt_q : cnt_q - 24'd1;
    in_text_d  = in_text_q;
    init_idx_d = init_idx_q;
    line_d     = line_q;
    cmd_d      = cmd_q;
    chr_d      = chr_q;
    pend_d     = pend_q | refresh;
    busy_d     = busy_q;
    done_d     = done_q;
    rs_d       = rs_q;
    db_d       = db_q;
    addr_d     = addr_q;
    start_text = 1'b0;

    case (state_q)
      S_POR: if (cnt_zero) begin
        state_d = S_SETUP;
        cnt_d   = T_US;
        rs_d    = 1'b0;
        db_d    = init_byte(3'd0);
      end
      S_SETUP: if (cnt_zero) begin
        state_d = S_EHIGH;
        cnt_d   = T_US;
      end
      S_EHIGH: if (cnt_zero) begin
        state_d = S_HOLD;
        cnt_d   = T_US;
      end
      S_HOLD: if (cnt_zero) begin
        state_d = S_EXEC;
        // The first two init writes carry the long function-set settle times.
        if (!in_text_q && init_idx_q == 3'd0)      cnt_d = T_4100;
        else if (!in_text_q && init_idx_q == 3'd1) cnt_d = T_100;
        else if (!rs_q && db_q == 8'h01)           cnt_d = T_1640;
        else                                       cnt_d = T_40;
      end
      S_EXEC: if (cnt_zero) begin
        if (!in_text_q) begin
          if (init_idx_q == 3'd7) begin
            start_text = 1'b1;
          end else begin
            init_idx_d = init_nxt;
            state_d    = S_SETUP;
            cnt_d      = T_US;
            db_d       = init_byte(init_nxt);
          end
        end else if (cmd_q) begin
          cmd_d   = 1'b0;
          chr_d   = 6'd0;
          state_d = S_FETCH;
          addr_d  = {line_q, 6'd0};
        end else if (chr_q != LAST_CHR) begin
          chr_d   = chr_nxt;
          state_d = S_FETCH;
          addr_d  = {line_q, chr_nxt};
        end else if (!line_q) begin
          line_d  = 1'b1;
          cmd_d   = 1'b1;
          state_d = S_SETUP;
          cnt_d   = T_US;
          rs_d    = 1'b0;
          db_d    = 8'hC0;
        end else begin
          done_d = 1'b1;
          // A refresh seen during the pass (or right now) chains straight into a new pass.
          if (pend_d) begin
            start_text = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      S_FETCH: begin
        state_d = S_SETUP;
        cnt_d   = T_US;
        rs_d    = 1'b1;
        db_d    = rom_data;
      end
      S_IDLE: if (refresh) start_text = 1'b1;
      default: begin
        state_d = S_POR;
        cnt_d   = T_POR;
      end
    endcase

    if (start_text) begin
      in_text_d = 1'b1;
      line_d    = 1'b0;
      cmd_d     = 1'b1;
      chr_d     = 6'd0;
      state_d   = S_SETUP;
      cnt_d     = T_US;
      rs_d      = 1'b0;
      db_d      = 8'h80;
      pend_d    = 1'b0;
      busy_d    = 1'b1;
    end

    e_d = (state_d == S_EHIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_POR;
      cnt_q      <= T_POR;
      in_text_q  <= 1'b0;
      init_idx_q <= 3'd0;
      line_q     <= 1'b0;
      cmd_q      <= 1'b0;
      chr_q      <= 6'd0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      db_q       <= 8'h00;
      addr_q     <= 7'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_text_q  <= in_text_d;
      init_idx_q <= init_idx_d;
      line_q     <= line_d;
      cmd_q      <= cmd_d;
      chr_q      <= chr_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      e_q        <= e_d;
      rs_q       <= rs_d;
      db_q       <= db_d;
      addr_q     <= addr_d;
    end
  end

  assign rom_addr = addr_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign lcd_db   = db_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
